jtag_tap_ctrl: RTL and testbench
================================

// Module: jtag_tap_ctrl
// PURPOSE
//  IEEE 1149.1 TAP controller that sequences the test interface block. It runs the 16-state
//  TAP FSM from tms_i, holds the instruction register, and drives the DR-phase strobes and
//  instruction selects to the test interface. It owns the IDCODE and BYPASS data registers
//  and muxes TDO across the IR, its own DRs and the test interface chains.
// PARAMETERS
//  IR_LEN       4             instruction register width
//  IDCODE_VALUE 32'h1180_0001 value captured by IDCODE; bit0 must be 1
// PORTS
//  tck_i                    in   1  test clock; the only clock
//  trst_ni                  in   1  asynchronous, active-low reset
//  tms_i                    in   1  test mode select, sampled on posedge tck_i
//  tdi_i                    in   1  test data in; also forwarded to the chains by the test interface
//  tdo_o                    out  1  test data out, updated on negedge tck_i
//  tdo_oe_o                 out  1  TDO pad enable, high only while shifting
//  test_logic_reset_o       out  1  high in Test-Logic-Reset
//  capture_dr_o             out  1  high in Capture-DR
//  shift_dr_o               out  1  high in Shift-DR
//  pause_dr_o               out  1  high in Pause-DR
//  update_dr_o              out  1  high in Update-DR
//  extest_select_o          out  1  active instruction is EXTEST
//  sample_preload_select_o  out  1  active instruction is SAMPLE_PRELOAD
//  mbist_select_o           out  1  active instruction is MBIST
//  debug_select_o           out  1  active instruction is DEBUG
//  bs_chain_tdo_i           in   1  boundary-scan chain serial out
//  mbist_tdo_i              in   1  MBIST chain serial out
//  debug_tdo_i              in   1  debug chain serial out
// BEHAVIOUR
//  Reset and clocking
//   - trst_ni low forces state=TLR, ir_q=IDCODE, tdo_o=0, tdo_oe_o=0, bypass_q=0,
//     idcode_sr=IDCODE_VALUE.
//   - Strobes then follow the FSM: test_logic_reset_o=1, all other strobes 0.
//   - Asserting trst_ni mid-operation aborts any shift immediately. No partial IR/DR update is ever applied.
//  FSM
//   - Standard 16 states. The next state is chosen from tms_i on each posedge tck_i.
//   - From any state, five consecutive tms_i=1 reach TLR.
//  Strobes
//   - Pure combinational decode of the current state. Consumers act on the posedge that leaves that state.
//  Instruction register
//   - Capture-IR: ir_sr loads {IR_LEN-2 zeros, 2'b01}.
//   - Shift-IR: ir_sr <= {tdi_i, ir_sr[IR_LEN-1:1]}, LSB first.
//   - Update-IR: ir_q <= ir_sr. In TLR, ir_q <= IDCODE.
//  Opcodes
//   - 0000 EXTEST, 0001 SAMPLE_PRELOAD, 0010 IDCODE, 1000 MBIST, 1001 DEBUG, 1111 BYPASS.
//   - Any other code decodes as BYPASS.
//  Selects
//   - Decoded from ir_q only: one-hot or all-zero, and stable outside Update-IR.
//  IDCODE register (ir_q=IDCODE)
//   - Capture-DR: idcode_sr <= IDCODE_VALUE.
//   - Shift-DR: idcode_sr <= {tdi_i, idcode_sr[31:1]}.
//  BYPASS register (ir_q=BYPASS)
//   - Capture-DR: bypass_q <= 0.
//   - Shift-DR: bypass_q <= tdi_i.
//  TDO
//   - Registered on negedge tck_i.
//   - In Shift-IR: tdo_o <= ir_sr[0].
//   - In Shift-DR, by instruction: idcode_sr[0], bypass_q, bs_chain_tdo_i (EXTEST or SAMPLE_PRELOAD),
//     mbist_tdo_i or debug_tdo_i.
//   - tdo_oe_o <= (Shift-IR | Shift-DR) on the same negedge.
//   - Otherwise tdo_o <= 0 and tdo_oe_o <= 0.
//  Pause-IR/Pause-DR: all shift registers hold.
// TESTING
//  - Reset, then tms 1,1,1,1,1 from Shift-DR -> TLR, test_logic_reset_o=1, ir_q=0010, tdo_oe_o=0.
//  - From reset: tms 0,1,0,0, then 32 Shift-DR clocks -> tdo_o yields 32'h1180_0001 LSB first,
//    and tdo_oe_o=1 throughout.
//  - Shift-IR with tdi 0,0,0,0 -> tdo_o yields 1,0,0,0.
//    After Update-IR: extest_select_o=1 and the other selects are 0.
//  - IR=1111, shift tdi 1,0,1,1 in Shift-DR -> tdo_o shows 0,1,0,1 (one-bit delay).
//    IR=0110 behaves identically.
//  - IR=0001, 3 Shift-DR clocks, then Exit1 -> Pause-DR x4 -> Exit2 -> Shift-DR:
//    the shift_dr_o, pause_dr_o and update_dr_o pulses are exact, and tdo_o follows bs_chain_tdo_i.
//  - Drop trst_ni mid Shift-IR with 2 of 4 bits shifted -> TLR asynchronously,
//    ir_q=IDCODE, tdo_oe_o=0.

Source files
------------

// File: rtl/jtag_tap_ctrl_if.sv
// jtag_tap_ctrl_if: TAP serial pins, DR-phase strobes, instruction selects and chain returns
interface jtag_tap_ctrl_if;
  logic tms_i;
  logic tdi_i;
  logic tdo_o;
  logic tdo_oe_o;
  logic test_logic_reset_o;
  logic capture_dr_o;
  logic shift_dr_o;
  logic pause_dr_o;
  logic update_dr_o;
  logic extest_select_o;
  logic sample_preload_select_o;
  logic mbist_select_o;
  logic debug_select_o;
  logic bs_chain_tdo_i;
  logic mbist_tdo_i;
  logic debug_tdo_i;
  modport master (
    output tms_i, tdi_i, bs_chain_tdo_i, mbist_tdo_i, debug_tdo_i,
    input  tdo_o, tdo_oe_o, test_logic_reset_o, capture_dr_o, shift_dr_o, pause_dr_o,
           update_dr_o, extest_select_o, sample_preload_select_o, mbist_select_o, debug_select_o
  );
  modport slave (
    input  tms_i, tdi_i, bs_chain_tdo_i, mbist_tdo_i, debug_tdo_i,
    output tdo_o, tdo_oe_o, test_logic_reset_o, capture_dr_o, shift_dr_o, pause_dr_o,
           update_dr_o, extest_select_o, sample_preload_select_o, mbist_select_o, debug_select_o
  );
endinterface

// File: rtl/jtag_tap_ctrl.sv
// jtag_tap_ctrl: IEEE 1149.1 TAP FSM with IR, IDCODE/BYPASS DRs and TDO mux
module jtag_tap_ctrl #(
  parameter int          IR_LEN       = 4,
  parameter logic [31:0] IDCODE_VALUE = 32'h1180_0001
) (
  input logic            tck_i,
  input logic            trst_ni,
  jtag_tap_ctrl_if.slave jtag
);
  typedef enum logic [3:0] {
    TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PA_DR, EX2_DR, UPD_DR,
    SEL_IR, CAP_IR, SH_IR, EX1_IR, PA_IR, EX2_IR, UPD_IR
  } state_e;
  localparam logic [IR_LEN-1:0] OP_EXTEST = IR_LEN'(0);
  localparam logic [IR_LEN-1:0] OP_SAMPLE = IR_LEN'(1);
  localparam logic [IR_LEN-1:0] OP_IDCODE = IR_LEN'(2);
  localparam logic [IR_LEN-1:0] OP_MBIST  = IR_LEN'(8);
  localparam logic [IR_LEN-1:0] OP_DEBUG  = IR_LEN'(9);
  state_e            state_q, state_d;
  logic [IR_LEN-1:0] ir_q, ir_d, ir_sr_q, ir_sr_d;
  logic [31:0]       idcode_sr_q, idcode_sr_d;
  logic              bypass_q, bypass_d, tdo_q, tdo_d, tdo_oe_q, tdo_oe_d;
  logic              is_ext, is_sp, is_id, is_mb, is_dbg, is_byp;
  assign is_ext = ir_q == OP_EXTEST;
  assign is_sp  = ir_q == OP_SAMPLE;
  assign is_id  = ir_q == OP_IDCODE;
  assign is_mb  = ir_q == OP_MBIST;
  assign is_dbg = ir_q == OP_DEBUG;
  assign is_byp = !(is_ext || is_sp || is_id || is_mb || is_dbg);
  always_comb begin
    state_d = state_q;
    case (state_q)
      TLR:    state_d = jtag.tms_i ? TLR    : RTI;
      RTI:    state_d = jtag.tms_i ? SEL_DR : RTI;
      SEL_DR: state_d = jtag.tms_i ? SEL_IR : CAP_DR;
      CAP_DR: state_d = jtag.tms_i ? EX1_DR : SH_DR;
      SH_DR:  state_d = jtag.tms_i ? EX1_DR : SH_DR;
      EX1_DR: state_d = jtag.tms_i ? UPD_DR : PA_DR;
      PA_DR:  state_d = jtag.tms_i ? EX2_DR : PA_DR;
      EX2_DR: state_d = jtag.tms_i ? UPD_DR : SH_DR;
      UPD_DR: state_d = jtag.tms_i ? SEL_DR : RTI;
      SEL_IR: state_d = jtag.tms_i ? TLR    : CAP_IR;
      CAP_IR: state_d = jtag.tms_i ? EX1_IR : SH_IR;
      SH_IR:  state_d = jtag.tms_i ? EX1_IR : SH_IR;
      EX1_IR: state_d = jtag.tms_i ? UPD_IR : PA_IR;
      PA_IR:  state_d = jtag.tms_i ? EX2_IR : PA_IR;
      EX2_IR: state_d = jtag.tms_i ? UPD_IR : SH_IR;
      UPD_IR: state_d = jtag.tms_i ? SEL_DR : RTI;
    endcase
  end
  always_comb begin
    ir_sr_d     = state_q == CAP_IR ? OP_SAMPLE :
                  state_q == SH_IR  ? {jtag.tdi_i, ir_sr_q[IR_LEN-1:1]} : ir_sr_q;
    ir_d        = state_q == TLR ? OP_IDCODE : state_q == UPD_IR ? ir_sr_q : ir_q;
    idcode_sr_d = !is_id ? idcode_sr_q : state_q == CAP_DR ? IDCODE_VALUE :
                  state_q == SH_DR ? {jtag.tdi_i, idcode_sr_q[31:1]} : idcode_sr_q;
    bypass_d    = !is_byp ? bypass_q : state_q == CAP_DR ? 1'b0 :
                  state_q == SH_DR ? jtag.tdi_i : bypass_q;
    tdo_d       = state_q == SH_IR ? ir_sr_q[0] :
                  state_q != SH_DR ? 1'b0 :
                  is_id  ? idcode_sr_q[0] :
                  is_byp ? bypass_q :
                  (is_ext || is_sp) ? jtag.bs_chain_tdo_i :
                  is_mb  ? jtag.mbist_tdo_i : jtag.debug_tdo_i;
    tdo_oe_d    = state_q == SH_IR || state_q == SH_DR;
  end
  always_ff @(posedge tck_i or negedge trst_ni) begin
    if (!trst_ni) begin
      state_q     <= TLR;
      ir_q        <= OP_IDCODE;
      ir_sr_q     <= OP_SAMPLE;
      idcode_sr_q <= IDCODE_VALUE;
      bypass_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      ir_q        <= ir_d;
      ir_sr_q     <= ir_sr_d;
      idcode_sr_q <= idcode_sr_d;
      bypass_q    <= bypass_d;
    end
  end
  // TDO launches on the falling edge so the external tester samples a stable bit on the rising edge
  always_ff @(negedge tck_i or negedge trst_ni) begin
    if (!trst_ni) begin
      tdo_q    <= 1'b0;
      tdo_oe_q <= 1'b0;
    end else begin
      tdo_q    <= tdo_d;
      tdo_oe_q <= tdo_oe_d;
    end
  end
  assign jtag.tdo_o                   = tdo_q;
  assign jtag.tdo_oe_o                = tdo_oe_q;
  assign jtag.test_logic_reset_o      = state_q == TLR;
  assign jtag.capture_dr_o            = state_q == CAP_DR;
  assign jtag.shift_dr_o              = state_q == SH_DR;
  assign jtag.pause_dr_o              = state_q == PA_DR;
  assign jtag.update_dr_o             = state_q == UPD_DR;
  assign jtag.extest_select_o         = is_ext;
  assign jtag.sample_preload_select_o = is_sp;
  assign jtag.mbist_select_o          = is_mb;
  assign jtag.debug_select_o          = is_dbg;
endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// tb_jtag_tap_ctrl: randomized TAP stimulus checked by a queue scoreboard against a column-based TAP model
module tb_jtag_tap_ctrl;
  localparam logic [31:0] IDV = 32'h1180_0001;
  localparam int TLR = -2, RTI = -1, SEL = 0, CAP = 1, SH = 2, EX1 = 3, PA = 4, EX2 = 5, UPD = 6;
  logic tck = 1'b0;
  logic trst_n = 1'b0;
  jtag_tap_ctrl_if jif();
  jtag_tap_ctrl #(.IR_LEN(4), .IDCODE_VALUE(IDV)) dut (.tck_i(tck), .trst_ni(trst_n), .jtag(jif));
  always #5 tck = ~tck;
  int         loc = TLR;
  bit         irs = 1'b0;
  int         ir = 2;
  bit         ir_bits[$];
  bit         idq[$];
  bit         byp = 1'b0;
  logic [10:0] expq[$];
  int         checks = 0, passes = 0;
  function automatic int kind(input int c);
    case (c)
      0: return 0;
      1: return 1;
      2: return 2;
      8: return 3;
      9: return 4;
      default: return 5;
    endcase
  endfunction
  task automatic mreset();
    loc = TLR; irs = 1'b0; ir = 2; byp = 1'b0;
    ir_bits = '{1'b1, 1'b0, 1'b0, 1'b0};
    idq.delete();
    for (int i = 0; i < 32; i++) idq.push_back(IDV[i]);
  endtask
  // The two columns (DR and IR) share the same seven-step shape; only SEL differs at the top
  task automatic advance(input bit t);
    case (loc)
      TLR: loc = t ? TLR : RTI;
      RTI: if (t) begin loc = SEL; irs = 1'b0; end
      SEL: if (t) begin
             if (irs) loc = TLR; else irs = 1'b1;
           end else loc = CAP;
      CAP, SH: loc = t ? EX1 : SH;
      EX1: loc = t ? UPD : PA;
      PA:  loc = t ? EX2 : PA;
      EX2: loc = t ? UPD : SH;
      UPD: if (t) begin loc = SEL; irs = 1'b0; end else loc = RTI;
      default: loc = TLR;
    endcase
  endtask
  task automatic model(input bit t, input bit d, input bit bs, input bit mb, input bit dg);
    int k;
    bit tdo, oe;
    k = kind(ir);
    if (loc == TLR) ir = 2;
    if (irs && loc == CAP) ir_bits = '{1'b1, 1'b0, 1'b0, 1'b0};
    if (irs && loc == SH) begin void'(ir_bits.pop_front()); ir_bits.push_back(d); end
    if (irs && loc == UPD) begin
      ir = 0;
      foreach (ir_bits[i]) ir |= int'(ir_bits[i]) << i;
    end
    if (!irs && loc == CAP && k == 2) begin
      idq.delete();
      for (int i = 0; i < 32; i++) idq.push_back(IDV[i]);
    end
    if (!irs && loc == CAP && k == 5) byp = 1'b0;
    if (!irs && loc == SH && k == 2) begin void'(idq.pop_front()); idq.push_back(d); end
    if (!irs && loc == SH && k == 5) byp = d;
    advance(t);
    k = kind(ir);
    oe = loc == SH;
    tdo = 1'b0;
    if (loc == SH && irs) tdo = ir_bits[0];
    else if (loc == SH)
      case (k)
        0, 1: tdo = bs;
        2: tdo = idq[0];
        3: tdo = mb;
        4: tdo = dg;
        default: tdo = byp;
      endcase
    expq.push_back({tdo, oe, loc == TLR, !irs && loc == CAP, !irs && loc == SH,
                    !irs && loc == PA, !irs && loc == UPD, k == 0, k == 1, k == 3, k == 4});
  endtask
  task automatic step(input bit t, input bit d, input bit rp = 1'b0);
    bit bs, mb, dg;
    @(negedge tck);
    #2;
    bs = 1'($urandom); mb = 1'($urandom); dg = 1'($urandom);
    jif.tms_i = t; jif.tdi_i = d;
    jif.bs_chain_tdo_i = bs; jif.mbist_tdo_i = mb; jif.debug_tdo_i = dg;
    // Short pulse between edges: only an asynchronous reset can observe it
    if (rp) begin trst_n = 1'b0; #2; trst_n = 1'b1; mreset(); end
    model(t, d, bs, mb, dg);
  endtask
  task automatic goto_rti();
    repeat (5) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
  endtask
  task automatic load_ir(input bit [3:0] c);
    step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(i == 3, c[i]);
    step(1'b1, 1'b0); step(1'b0, 1'b0);
  endtask
  task automatic scan_dr(input int n);
    step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    for (int i = 0; i < n; i++) step(i == n - 1, 1'($urandom));
    step(1'b1, 1'b0); step(1'b0, 1'b0);
  endtask
  initial begin
    logic [10:0] e, got;
    forever begin
      @(negedge tck);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        got = {jif.tdo_o, jif.tdo_oe_o, jif.test_logic_reset_o, jif.capture_dr_o, jif.shift_dr_o,
               jif.pause_dr_o, jif.update_dr_o, jif.extest_select_o, jif.sample_preload_select_o,
               jif.mbist_select_o, jif.debug_select_o};
        checks++;
        if (got === e) passes++;
        else $display("FAIL obs t=%0t got=%b exp=%b (tdo,oe,tlr,cap,sh,pa,upd,ext,sp,mb,dbg)",
                      $time, got, e);
      end
    end
  end
  initial begin
    jif.tms_i = 1'b1; jif.tdi_i = 1'b0;
    jif.bs_chain_tdo_i = 1'b0; jif.mbist_tdo_i = 1'b0; jif.debug_tdo_i = 1'b0;
    mreset();
    repeat (2) @(negedge tck);
    step(1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    repeat (5) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    scan_dr(32);
    load_ir(4'h0);
    scan_dr(5);
    load_ir(4'hF); scan_dr(4);
    load_ir(4'h6); scan_dr(4);
    load_ir(4'h1);
    step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    step(1'b0, 1'b1); step(1'b0, 1'b0); step(1'b1, 1'b1);
    repeat (4) step(1'b0, 1'b0);
    step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b1, 1'b1); step(1'b1, 1'b0); step(1'b0, 1'b0);
    load_ir(4'h8); scan_dr(6);
    load_ir(4'h9); scan_dr(6);
    step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    step(1'b0, 1'b1); step(1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0);
    scan_dr(32);
    for (int r = 0; r < 40; r++) begin
      goto_rti();
      load_ir(4'($urandom));
      scan_dr(int'($urandom_range(1, 40)));
      for (int i = 0; i < 20; i++) step(1'($urandom), 1'($urandom), ($urandom % 50) == 0);
    end
    repeat (3) @(negedge tck);
    #5;
    if (expq.size() != 0) begin
      checks++;
      $display("FAIL drain pending=%0d required=0", expq.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
